// File: rtl/grant_responder_2ph_pkg.sv
// Shared definitions for the 2-phase grant responder: FSM encoding and port ids.
package grant_responder_2ph_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   localparam logic PORT_1 = 1'b0;
   localparam logic PORT_2 = 1'b1;

endpackage

// File: rtl/sync_2ff_n.sv
// N-deep single-bit synchroniser for asynchronous level/toggle inputs.
module sync_2ff_n #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sff;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sff <= '0;
      end else begin
         sff <= {sff[STAGES-2:0], d};
      end
   end

   assign q = sff[STAGES-1];

endmodule

// File: rtl/grant_responder_2ph.sv
// Clocked responder for a 2-phase two-way arbiter: synchronises grant toggles,
// serves one port at a time and returns a done toggle when local logic accepts.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no service in flight; pick port 1 first, then port 2
// ST_SERVE | srv_valid high for srv_id; wait for srv_ready, watchdog running
module grant_responder_2ph
   import grant_responder_2ph_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int TMO_W       = 8,
   parameter int TMO_MAX     = 200
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             g1,
   input  logic             g2,
   output logic             d1,
   output logic             d2,
   output logic             srv_valid,
   output logic             srv_id,
   input  logic             srv_ready,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic             err_overlap,
   output logic             err_timeout
);

   // Watchdog is a down-counter loaded on entry; terminal count at zero.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_MAX - 1);

   logic             g1_s;
   logic             g2_s;
   logic             pend1;
   logic             pend2;
   state_t           state;
   logic [TMO_W-1:0] wdog;

   sync_2ff_n #(.STAGES(SYNC_STAGES)) u_sync_g1 (
      .clk  (clk),
      .rstn (rstn),
      .d    (g1),
      .q    (g1_s)
   );

   sync_2ff_n #(.STAGES(SYNC_STAGES)) u_sync_g2 (
      .clk  (clk),
      .rstn (rstn),
      .d    (g2),
      .q    (g2_s)
   );

   assign pend1 = g1_s ^ d1;
   assign pend2 = g2_s ^ d2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         d1          <= 1'b0;
         d2          <= 1'b0;
         srv_valid   <= 1'b0;
         srv_id      <= PORT_1;
         cnt1        <= '0;
         cnt2        <= '0;
         err_overlap <= 1'b0;
         err_timeout <= 1'b0;
         wdog        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               srv_valid <= 1'b0;
               if (pend1 && pend2) begin
                  err_overlap <= 1'b1;
               end
               if (pend1) begin
                  state     <= ST_SERVE;
                  srv_id    <= PORT_1;
                  srv_valid <= 1'b1;
                  wdog      <= TMO_LOAD;
               end else if (pend2) begin
                  state     <= ST_SERVE;
                  srv_id    <= PORT_2;
                  srv_valid <= 1'b1;
                  wdog      <= TMO_LOAD;
               end
            end
            ST_SERVE: begin
               if (srv_valid && srv_ready) begin
                  if (srv_id == PORT_1) begin
                     d1   <= ~d1;
                     cnt1 <= cnt1 + CNT_W'(1);
                  end else begin
                     d2   <= ~d2;
                     cnt2 <= cnt2 + CNT_W'(1);
                  end
                  srv_valid <= 1'b0;
                  state     <= ST_IDLE;
               end else if (wdog == '0) begin
                  // A stuck service is flagged but the grant is never dropped.
                  err_timeout <= 1'b1;
               end else begin
                  wdog <= wdog - TMO_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               srv_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grant_responder_2ph.sv
// Directed bench for grant_responder_2ph; narrow counters so wrap is reachable.
module tb_grant_responder_2ph;

   localparam int TMO_MAX = 200;

   logic       clk;
   logic       rstn;
   logic       g1;
   logic       g2;
   logic       d1;
   logic       d2;
   logic       srv_valid;
   logic       srv_id;
   logic       srv_ready;
   logic [1:0] cnt1;
   logic [1:0] cnt2;
   logic       err_overlap;
   logic       err_timeout;

   int n_chk = 0;
   int n_bad = 0;

   grant_responder_2ph #(
      .SYNC_STAGES (2),
      .CNT_W       (2),
      .TMO_W       (8),
      .TMO_MAX     (TMO_MAX)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .g1          (g1),
      .g2          (g2),
      .d1          (d1),
      .d2          (d2),
      .srv_valid   (srv_valid),
      .srv_id      (srv_id),
      .srv_ready   (srv_ready),
      .cnt1        (cnt1),
      .cnt2        (cnt2),
      .err_overlap (err_overlap),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      g1        = 1'b0;
      g2        = 1'b0;
      srv_ready = 1'b0;
      rstn      = 1'b0;
      tick(2);
      rstn = 1'b1;
      tick(1);
   endtask

   initial begin
      g1        = 1'b0;
      g2        = 1'b0;
      srv_ready = 1'b0;
      rstn      = 1'b0;

      // reset state
      tick(3);
      chk("rst_d1", 32'(d1), 0);
      chk("rst_d2", 32'(d2), 0);
      chk("rst_valid", 32'(srv_valid), 0);
      chk("rst_id", 32'(srv_id), 0);
      chk("rst_cnt1", 32'(cnt1), 0);
      chk("rst_cnt2", 32'(cnt2), 0);
      chk("rst_ovl", 32'(err_overlap), 0);
      chk("rst_tmo", 32'(err_timeout), 0);
      rstn = 1'b1;
      tick(4);
      chk("idle_valid", 32'(srv_valid), 0);

      // single grant, port 1, ready already high
      srv_ready = 1'b1;
      g1 = 1'b1;
      tick(2);
      chk("lat_early", 32'(srv_valid), 0);
      tick(1);
      chk("lat_valid", 32'(srv_valid), 1);
      chk("lat_id", 32'(srv_id), 0);
      chk("lat_d1_pre", 32'(d1), 0);
      tick(1);
      chk("acc_d1", 32'(d1), 1);
      chk("acc_cnt1", 32'(cnt1), 1);
      chk("acc_valid", 32'(srv_valid), 0);
      g1 = 1'b0;
      tick(3);
      chk("g1b_valid", 32'(srv_valid), 1);
      tick(1);
      chk("g1b_d1", 32'(d1), 0);
      chk("g1b_cnt1", 32'(cnt1), 2);

      // back-pressure on port 2
      srv_ready = 1'b0;
      g2 = 1'b1;
      tick(3);
      chk("bp_valid", 32'(srv_valid), 1);
      chk("bp_id", 32'(srv_id), 1);
      tick(10);
      chk("bp_hold_valid", 32'(srv_valid), 1);
      chk("bp_hold_id", 32'(srv_id), 1);
      chk("bp_hold_d2", 32'(d2), 0);
      chk("bp_hold_cnt2", 32'(cnt2), 0);
      srv_ready = 1'b1;
      tick(1);
      chk("bp_d2", 32'(d2), 1);
      chk("bp_cnt2", 32'(cnt2), 1);
      chk("bp_valid_drop", 32'(srv_valid), 0);
      chk("bp_no_ovl", 32'(err_overlap), 0);

      // overlapping grants: port 1 first, then port 2
      do_reset();
      srv_ready = 1'b1;
      g1 = 1'b1;
      g2 = 1'b1;
      tick(3);
      chk("ovl_flag", 32'(err_overlap), 1);
      chk("ovl_first_valid", 32'(srv_valid), 1);
      chk("ovl_first_id", 32'(srv_id), 0);
      tick(1);
      chk("ovl_d1", 32'(d1), 1);
      chk("ovl_d2_wait", 32'(d2), 0);
      chk("ovl_gap", 32'(srv_valid), 0);
      tick(1);
      chk("ovl_second_valid", 32'(srv_valid), 1);
      chk("ovl_second_id", 32'(srv_id), 1);
      tick(1);
      chk("ovl_d2", 32'(d2), 1);
      chk("ovl_cnt1", 32'(cnt1), 1);
      chk("ovl_cnt2", 32'(cnt2), 1);
      chk("ovl_sticky", 32'(err_overlap), 1);

      // watchdog: flag after TMO_MAX cycles in SERVE, grant still honoured
      srv_ready = 1'b0;
      g1 = 1'b0;
      tick(3);
      chk("tmo_valid", 32'(srv_valid), 1);
      tick(TMO_MAX - 1);
      chk("tmo_before", 32'(err_timeout), 0);
      tick(1);
      chk("tmo_at", 32'(err_timeout), 1);
      tick(5);
      chk("tmo_still_valid", 32'(srv_valid), 1);
      chk("tmo_d1_held", 32'(d1), 1);
      srv_ready = 1'b1;
      tick(1);
      chk("tmo_late_d1", 32'(d1), 0);
      chk("tmo_late_cnt1", 32'(cnt1), 2);
      chk("tmo_sticky", 32'(err_timeout), 1);

      // reset while serving port 2 with d1 already high
      do_reset();
      srv_ready = 1'b1;
      g1 = 1'b1;
      tick(5);
      chk("mid_pre_d1", 32'(d1), 1);
      srv_ready = 1'b0;
      g2 = 1'b1;
      tick(3);
      chk("mid_pre_valid", 32'(srv_valid), 1);
      #2;
      rstn = 1'b0;
      g1 = 1'b0;
      g2 = 1'b0;
      #1;
      chk("mid_d1", 32'(d1), 0);
      chk("mid_d2", 32'(d2), 0);
      chk("mid_valid", 32'(srv_valid), 0);
      tick(2);
      rstn = 1'b1;
      tick(4);
      chk("mid_post_valid", 32'(srv_valid), 0);
      chk("mid_post_cnt2", 32'(cnt2), 0);

      // 2-bit counter wraps: 5 services leave cnt1 at 1
      srv_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         g1 = ~g1;
         tick(5);
      end
      chk("wrap_cnt1", 32'(cnt1), 1);
      chk("wrap_d1", 32'(d1), 1);
      chk("wrap_cnt2", 32'(cnt2), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
